// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I integer subset with separate instruction and data ports.
// The PC pair (pc_q, npc_q) implements the architectural branch delay slot.
module mips_cpu_harvard #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    logic [31:0] pc_q, npc_q, pc_d, npc_d;
    logic [31:0] hi_q, lo_q, hi_d, lo_d;
    logic        active_q;
    logic [31:0] gpr_q [0:31];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jindex;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
    logic [31:0] pc_plus4, br_target;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    logic        wr_en, jump, enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, jump_target;

    assign opcode   = instr_readdata[31:26];
    assign rs       = instr_readdata[25:21];
    assign rt       = instr_readdata[20:16];
    assign rd       = instr_readdata[15:11];
    assign shamt    = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign imm      = instr_readdata[15:0];
    assign jindex   = instr_readdata[25:0];

    assign rs_val   = gpr_q[rs];
    assign rt_val   = gpr_q[rt];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign pc_plus4 = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
    // Results are only consumed when the divisor is non-zero.
    assign quot_s = 32'($signed(rs_val) / $signed(rt_val));
    assign rem_s  = 32'($signed(rs_val) % $signed(rt_val));
    assign quot_u = rs_val / rt_val;
    assign rem_u  = rs_val % rt_val;

    assign enable         = clk_enable && active_q;
    assign active         = active_q;
    assign register_v0    = gpr_q[2];
    assign instr_address  = pc_q;
    assign data_address   = rs_val + imm_sext;
    assign data_writedata = rt_val;
    assign data_read      = active_q && (opcode == OP_LW);
    assign data_write     = enable && (opcode == OP_SW);

    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = rd;
        wr_data     = 32'h0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        jump        = 1'b0;
        jump_target = 32'h0;
        case (opcode)
            OP_R: begin
                wr_en = 1'b1;
                case (funct)
                    F_SLL:   wr_data = rt_val << shamt;
                    F_SRL:   wr_data = rt_val >> shamt;
                    F_SRA:   wr_data = 32'($signed(rt_val) >>> shamt);
                    F_MFHI:  wr_data = hi_q;
                    F_MFLO:  wr_data = lo_q;
                    F_ADDU:  wr_data = rs_val + rt_val;
                    F_SUBU:  wr_data = rs_val - rt_val;
                    F_AND:   wr_data = rs_val & rt_val;
                    F_OR:    wr_data = rs_val | rt_val;
                    F_XOR:   wr_data = rs_val ^ rt_val;
                    F_SLT:   wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU:  wr_data = {31'h0, rs_val < rt_val};
                    F_JR: begin
                        wr_en       = 1'b0;
                        jump        = 1'b1;
                        jump_target = rs_val;
                    end
                    F_MTHI: begin
                        wr_en = 1'b0;
                        hi_d  = rs_val;
                    end
                    F_MTLO: begin
                        wr_en = 1'b0;
                        lo_d  = rs_val;
                    end
                    F_MULT: begin
                        wr_en        = 1'b0;
                        {hi_d, lo_d} = prod_s;
                    end
                    F_MULTU: begin
                        wr_en        = 1'b0;
                        {hi_d, lo_d} = prod_u;
                    end
                    F_DIV: begin
                        wr_en = 1'b0;
                        if (rt_val != 32'h0) begin
                            lo_d = quot_s;
                            hi_d = rem_s;
                        end
                    end
                    F_DIVU: begin
                        wr_en = 1'b0;
                        if (rt_val != 32'h0) begin
                            lo_d = quot_u;
                            hi_d = rem_u;
                        end
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_J: begin
                jump        = 1'b1;
                jump_target = {pc_plus4[31:28], jindex, 2'b00};
            end
            OP_JAL: begin
                jump        = 1'b1;
                jump_target = {pc_plus4[31:28], jindex, 2'b00};
                wr_en       = 1'b1;
                wr_addr     = 5'd31;
                wr_data     = pc_q + 32'd8;
            end
            OP_BEQ: begin
                jump        = (rs_val == rt_val);
                jump_target = br_target;
            end
            OP_BNE: begin
                jump        = (rs_val != rt_val);
                jump_target = br_target;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                wr_en   = 1'b1;
                wr_addr = rt;
                case (opcode)
                    OP_ADDIU: wr_data = rs_val + imm_sext;
                    OP_SLTI:  wr_data = {31'h0, $signed(rs_val) < $signed(imm_sext)};
                    OP_SLTIU: wr_data = {31'h0, rs_val < imm_sext};
                    OP_ANDI:  wr_data = rs_val & imm_zext;
                    OP_ORI:   wr_data = rs_val | imm_zext;
                    OP_XORI:  wr_data = rs_val ^ imm_zext;
                    OP_LUI:   wr_data = {imm, 16'h0000};
                    default:  wr_data = data_readdata;
                endcase
            end
            default: ;
        endcase
        // Delay slot: the instruction after a control transfer always runs.
        pc_d  = npc_q;
        npc_d = jump ? jump_target : npc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            npc_q    <= RESET_VECTOR + 32'd4;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            active_q <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 32'h0;
            end
        end else if (enable) begin
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            active_q <= (pc_d != 32'h0);
            if (wr_en && (wr_addr != 5'd0)) begin
                gpr_q[wr_addr] <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed bench for mips_cpu_harvard: small programs with hand-computed results.
module tb_mips_cpu_harvard;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        active;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_write, data_read;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15];
    logic [31:0] ioff;
    int checks = 0;
    int passes = 0;

    mips_cpu_harvard dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .data_address(data_address),
        .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    // Address 0 holds a load into $2 so a halted core that kept running would show it.
    always_comb begin
        ioff = instr_address - BASE;
        if (instr_address == 32'h0)
            instr_readdata = enc_i(6'h23, 5'd0, 5'd2, 16'h0000);
        else if (ioff[31:8] == 24'h0)
            instr_readdata = imem[ioff[7:2]];
        else
            instr_readdata = 32'h0;
    end

    assign data_readdata = (data_address == 32'h8) ? 32'h00001234 : dmem[data_address[5:2]];
    always @(posedge clk) begin
        if (data_write) dmem[data_address[5:2]] <= data_writedata;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %08h expected %08h", name, got, exp);
        else begin
            passes++;
            $display("ok   %s: %08h", name, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        clk_enable = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic clear_imem;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic test_reset;
        clear_imem();
        do_reset();
        checks++;
        if (instr_address !== BASE) $display("FAIL reset_pc: got %08h expected %08h", instr_address, BASE);
        else passes++;
        checks++;
        if (register_v0 !== 32'h0) $display("FAIL reset_v0: got %08h expected 0", register_v0);
        else passes++;
        checks++;
        if (active !== 1'b1) $display("FAIL reset_active: got %0b expected 1", active);
        else passes++;
        step(1);
        checks++;
        if (instr_address !== BASE + 32'd4) $display("FAIL reset_pc_next: got %08h expected %08h", instr_address, BASE + 32'd4);
        else passes++;
        $display("test_reset done");
    endtask

    task automatic test_alu;
        logic [31:0] exp_v0 [0:16];
        clear_imem();
        imem[0]  = enc_i(6'h0D, 5'd0, 5'd4, 16'hF0F0);
        imem[1]  = enc_i(6'h0F, 5'd0, 5'd5, 16'h8000);
        imem[2]  = enc_i(6'h0E, 5'd4, 5'd2, 16'hFFFF);
        imem[3]  = enc_i(6'h0C, 5'd4, 5'd2, 16'hFF00);
        imem[4]  = enc_r(5'd0, 5'd5, 5'd2, 5'd4, 6'h03);
        imem[5]  = enc_r(5'd0, 5'd5, 5'd2, 5'd4, 6'h02);
        imem[6]  = enc_r(5'd0, 5'd4, 5'd2, 5'd8, 6'h00);
        imem[7]  = enc_r(5'd5, 5'd4, 5'd2, 5'd0, 6'h2A);
        imem[8]  = enc_r(5'd5, 5'd4, 5'd2, 5'd0, 6'h2B);
        imem[9]  = enc_r(5'd4, 5'd5, 5'd2, 5'd0, 6'h23);
        imem[10] = enc_i(6'h0A, 5'd4, 5'd2, 16'hFFFF);
        imem[11] = enc_i(6'h0B, 5'd4, 5'd2, 16'hFFFF);
        imem[12] = enc_r(5'd4, 5'd5, 5'd2, 5'd0, 6'h24);
        imem[13] = enc_i(6'h09, 5'd0, 5'd0, 16'h0005);
        imem[14] = enc_r(5'd0, 5'd4, 5'd2, 5'd0, 6'h25);
        imem[15] = enc_r(5'd4, 5'd5, 5'd2, 5'd0, 6'h26);
        imem[16] = enc_r(5'd5, 5'd5, 5'd2, 5'd0, 6'h21);
        exp_v0 = '{32'h0, 32'h0, 32'h00000F0F, 32'h0000F000, 32'hF8000000, 32'h08000000,
                   32'h00F0F000, 32'h1, 32'h0, 32'h8000F0F0, 32'h0, 32'h1, 32'h0, 32'h0,
                   32'h0000F0F0, 32'h8000F0F0, 32'h0};
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(1);
            checks++;
            if (register_v0 !== exp_v0[k])
                $display("FAIL alu_step%0d: got %08h expected %08h", k, register_v0, exp_v0[k]);
            else passes++;
        end
        $display("test_alu done");
    endtask

    task automatic test_divu;
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd1, 5'd3, 16'd32);
        imem[1] = enc_i(6'h09, 5'd3, 5'd2, 16'hFF7F);
        imem[2] = enc_r(5'd2, 5'd3, 5'd0, 5'd0, 6'h1B);
        imem[3] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[4] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h12);
        do_reset();
        step(2);
        check("divu_addiu", register_v0, 32'hFFFFFF9F);
        step(2);
        check("divu_mfhi", register_v0, 32'h0000001F);
        step(1);
        check("divu_mflo", register_v0, 32'h07FFFFFC);
    endtask

    task automatic test_div;
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd3, 16'd32);
        imem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'hFF9F);
        imem[2] = enc_r(5'd2, 5'd3, 5'd0, 5'd0, 6'h1A);
        imem[3] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h12);
        imem[4] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[5] = enc_r(5'd2, 5'd0, 5'd0, 5'd0, 6'h1A);
        imem[6] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h12);
        imem[7] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        do_reset();
        step(4);
        check("div_lo", register_v0, 32'hFFFFFFFD);
        step(1);
        check("div_hi", register_v0, 32'hFFFFFFFF);
        step(2);
        check("div0_lo_kept", register_v0, 32'hFFFFFFFD);
        step(1);
        check("div0_hi_kept", register_v0, 32'hFFFFFFFF);
    endtask

    task automatic test_mult;
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFD);
        imem[1] = enc_i(6'h09, 5'd0, 5'd3, 16'd5);
        imem[2] = enc_r(5'd2, 5'd3, 5'd0, 5'd0, 6'h18);
        imem[3] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h12);
        imem[4] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[5] = enc_i(6'h09, 5'd0, 5'd4, 16'hFFFF);
        imem[6] = enc_i(6'h09, 5'd0, 5'd5, 16'd2);
        imem[7] = enc_r(5'd4, 5'd5, 5'd0, 5'd0, 6'h19);
        imem[8] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[9] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h12);
        do_reset();
        step(4);
        check("mult_lo", register_v0, 32'hFFFFFFF1);
        step(1);
        check("mult_hi", register_v0, 32'hFFFFFFFF);
        step(4);
        check("multu_hi", register_v0, 32'h00000001);
        step(1);
        check("multu_lo", register_v0, 32'hFFFFFFFE);
    endtask

    task automatic test_load_store;
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'h5A5A);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'd4);
        imem[2] = enc_i(6'h23, 5'd0, 5'd2, 16'd8);
        imem[3] = enc_i(6'h23, 5'd0, 5'd2, 16'd4);
        do_reset();
        step(1);
        check("ls_addiu", register_v0, 32'h00005A5A);
        clk_enable = 1'b0;
        #1;
        check("sw_gated_write", {31'h0, data_write}, 32'h0);
        step(1);
        check("stall_pc", instr_address, BASE + 32'd4);
        clk_enable = 1'b1;
        #1;
        check("sw_write", {31'h0, data_write}, 32'h1);
        check("sw_addr", data_address, 32'h4);
        check("sw_data", data_writedata, 32'h00005A5A);
        check("sw_read", {31'h0, data_read}, 32'h0);
        step(1);
        check("lw_read", {31'h0, data_read}, 32'h1);
        check("lw_addr", data_address, 32'h8);
        step(1);
        check("lw_value", register_v0, 32'h00001234);
        step(1);
        check("lw_roundtrip", register_v0, 32'h00005A5A);
    endtask

    task automatic test_branch_jump_halt;
        logic [31:0] jt;
        jt = BASE + 32'd32;
        clear_imem();
        imem[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
        imem[1]  = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        imem[2]  = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
        imem[3]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0077);
        imem[4]  = enc_j(6'h03, jt[27:2]);
        imem[5]  = enc_i(6'h09, 5'd2, 5'd2, 16'd4);
        imem[6]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0099);
        imem[8]  = enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
        imem[9]  = enc_i(6'h05, 5'd2, 5'd0, 16'd1);
        imem[10] = enc_i(6'h09, 5'd0, 5'd2, 16'd3);
        imem[11] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[12] = enc_i(6'h09, 5'd2, 5'd2, 16'd5);
        imem[13] = enc_i(6'h09, 5'd0, 5'd2, 16'h0055);
        do_reset();
        step(1);
        check("br_pre", register_v0, 32'h1);
        step(1);
        check("beq_delay_pc", instr_address, BASE + 32'd8);
        step(1);
        check("beq_delay_exec", register_v0, 32'h2);
        check("beq_target", instr_address, BASE + 32'd16);
        step(2);
        check("jal_delay_exec", register_v0, 32'h6);
        check("jal_target", instr_address, BASE + 32'd32);
        step(1);
        check("jal_link", register_v0, BASE + 32'd24);
        step(2);
        check("bne_delay_exec", register_v0, 32'h3);
        check("bne_target", instr_address, BASE + 32'd44);
        step(1);
        check("jr_active", {31'h0, active}, 32'h1);
        step(1);
        check("halt_active", {31'h0, active}, 32'h0);
        check("halt_delay_exec", register_v0, 32'h8);
        check("halt_pc", instr_address, 32'h0);
        step(3);
        check("frozen_v0", register_v0, 32'h8);
        check("frozen_active", {31'h0, active}, 32'h0);
        check("frozen_read", {31'h0, data_read}, 32'h0);
        check("frozen_pc", instr_address, 32'h0);
    endtask

    task automatic test_back_to_back;
        do_reset();
        check("rearm_active", {31'h0, active}, 32'h1);
        check("rearm_pc", instr_address, BASE);
        check("rearm_v0", register_v0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_divu();
        test_div();
        test_mult();
        test_load_store();
        test_branch_jump_halt();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
